// File: rtl/glm_load.sv
// DRAM-to-BRAM loader: resolves a cache-line address, launches one DMA read and
// streams the returned lines into a selected BRAM. Optional GLM_LOAD_PERF_EN adds perf_cycles.
module glm_load #(
   parameter int NUM_LOAD_CHANNELS = 2,
   parameter int BRAM_AW           = 10,
   parameter int CLADDR_W          = 42
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         op_start,
   output logic                         op_done,
   input  logic [7:0][31:0]             regs,
   input  logic [CLADDR_W-1:0]          in_addr,
   input  logic [CLADDR_W-1:0]          out_addr,
   output logic                         dma_start,
   output logic [CLADDR_W-1:0]          dma_addr,
   output logic [32:0]                  dma_len,
   input  logic                         dma_idle,
   input  logic                         dma_active,
   input  logic                         rd_valid,
   input  logic [511:0]                 rd_data,
   output logic                         rd_almostfull,
   output logic [NUM_LOAD_CHANNELS-1:0] bram_we,
   output logic [BRAM_AW-1:0]           bram_waddr,
   output logic [511:0]                 bram_wdata
`ifdef GLM_LOAD_PERF_EN
   ,
   output logic [31:0]                  perf_cycles
`endif
);

   typedef enum logic [2:0] {IDLE, PREPROCESS, TRIGGER, READ, DONE} state_t;

   state_t                         state_reg, state_next;
   logic [CLADDR_W-1:0]            addr_reg;
   logic [2:0][31:0]               offsets_reg;
   logic [1:0]                     pp_cnt_reg;
   logic [31:0]                    len_reg;
   logic [31:0]                    line_cnt_reg;
   logic [3:0]                     ch_reg;
   logic [BRAM_AW-1:0]             start_reg, depth_reg, ptr_reg;
   logic [BRAM_AW-1:0]             wrap_last;
   logic                           accept, last_line;
   logic                           op_done_reg, dma_start_reg, rd_almostfull_reg;
   logic [CLADDR_W-1:0]            dma_addr_reg;
   logic [32:0]                    dma_len_reg;
   logic [NUM_LOAD_CHANNELS-1:0]   bram_we_reg, we_next;
   logic [BRAM_AW-1:0]             bram_waddr_reg;
   logic [511:0]                   bram_wdata_reg;
   logic                           unused_reg_bits;

   assign unused_reg_bits = ^{regs[5][31:4], regs[6][31:BRAM_AW], regs[7][31:BRAM_AW]};

   assign accept    = (state_reg == READ) && rd_valid;
   assign last_line = accept && (line_cnt_reg == len_reg - 32'd1);
   assign wrap_last = start_reg + depth_reg - BRAM_AW'(1);

   // Out-of-range channel numbers simply match no write-enable bit.
   generate
      for (genvar gi = 0; gi < NUM_LOAD_CHANNELS; gi++) begin : g_we
         assign we_next[gi] = accept && (ch_reg == 4'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:       if (op_start) state_next = (regs[4] == 32'd0) ? DONE : PREPROCESS;
         PREPROCESS: if (pp_cnt_reg == 2'd2) state_next = TRIGGER;
         TRIGGER:    if (dma_idle) state_next = READ;
         READ:       if (last_line) state_next = DONE;
         DONE:       state_next = IDLE;
         default:    state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_reg          <= '0;
         offsets_reg       <= '0;
         pp_cnt_reg        <= '0;
         len_reg           <= '0;
         line_cnt_reg      <= '0;
         ch_reg            <= '0;
         start_reg         <= '0;
         depth_reg         <= '0;
         ptr_reg           <= '0;
         op_done_reg       <= 1'b0;
         dma_start_reg     <= 1'b0;
         rd_almostfull_reg <= 1'b1;
         dma_addr_reg      <= '0;
         dma_len_reg       <= '0;
         bram_we_reg       <= '0;
         bram_waddr_reg    <= '0;
         bram_wdata_reg    <= '0;
      end else begin
         dma_start_reg     <= 1'b0;
         op_done_reg       <= (state_reg == DONE);
         rd_almostfull_reg <= !((state_reg == READ) && dma_active);
         bram_we_reg       <= we_next;
         case (state_reg)
            IDLE: if (op_start) begin
               addr_reg     <= (regs[3][31] ? in_addr : out_addr) + CLADDR_W'(regs[3][30:0]);
               offsets_reg  <= regs[2:0];
               pp_cnt_reg   <= '0;
               len_reg      <= regs[4];
               line_cnt_reg <= '0;
               ch_reg       <= regs[5][3:0];
               start_reg    <= regs[6][BRAM_AW-1:0];
               depth_reg    <= regs[7][BRAM_AW-1:0];
               ptr_reg      <= regs[6][BRAM_AW-1:0];
            end
            // Offsets shift down so each preprocess cycle adds the next one.
            PREPROCESS: begin
               addr_reg    <= addr_reg + CLADDR_W'(offsets_reg[0]);
               offsets_reg <= {32'd0, offsets_reg[2:1]};
               pp_cnt_reg  <= pp_cnt_reg + 2'd1;
            end
            TRIGGER: if (dma_idle) begin
               dma_start_reg <= 1'b1;
               dma_addr_reg  <= addr_reg;
               dma_len_reg   <= {1'b0, len_reg};
            end
            default: ;
         endcase
         if (accept) begin
            bram_wdata_reg <= rd_data;
            bram_waddr_reg <= ptr_reg;
            line_cnt_reg   <= line_cnt_reg + 32'd1;
            if ((depth_reg != '0) && (ptr_reg == wrap_last)) ptr_reg <= start_reg;
            else                                            ptr_reg <= ptr_reg + BRAM_AW'(1);
         end
      end
   end

   assign op_done       = op_done_reg;
   assign dma_start     = dma_start_reg;
   assign dma_addr      = dma_addr_reg;
   assign dma_len       = dma_len_reg;
   assign rd_almostfull = rd_almostfull_reg;
   assign bram_we       = bram_we_reg;
   assign bram_waddr    = bram_waddr_reg;
   assign bram_wdata    = bram_wdata_reg;

`ifdef GLM_LOAD_PERF_EN
   // Window runs from the dma_start cycle through the op_done cycle inclusive.
   logic [31:0] perf_cnt_reg;
   logic        perf_run_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_cnt_reg <= '0;
         perf_run_reg <= 1'b0;
      end else if ((state_reg == IDLE) && op_start) begin
         perf_cnt_reg <= '0;
         perf_run_reg <= 1'b0;
      end else if (dma_start_reg || perf_run_reg) begin
         perf_cnt_reg <= perf_cnt_reg + 32'd1;
         perf_run_reg <= !op_done_reg;
      end
   end

   assign perf_cycles = perf_cnt_reg;
`endif

endmodule

// File: tb/tb_glm_load.sv
// Self-checking bench for glm_load: directed scenarios plus randomized operations
// compared against a plain-arithmetic reference of address, write list and timing.
`timescale 1ns/1ps
module tb_glm_load;
   localparam int NCH = 2;
   localparam int AW  = 10;
   localparam int CW  = 42;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            op_start = 1'b0;
   logic            op_done;
   logic [7:0][31:0] regs = '0;
   logic [CW-1:0]   in_addr = '0, out_addr = '0;
   logic            dma_start;
   logic [CW-1:0]   dma_addr;
   logic [32:0]     dma_len;
   logic            dma_idle = 1'b1, dma_active = 1'b0;
   logic            rd_valid = 1'b0;
   logic [511:0]    rd_data = '0;
   logic            rd_almostfull;
   logic [NCH-1:0]  bram_we;
   logic [AW-1:0]   bram_waddr;
   logic [511:0]    bram_wdata;

   glm_load #(.NUM_LOAD_CHANNELS(NCH), .BRAM_AW(AW), .CLADDR_W(CW)) dut (
      .clk(clk), .reset(reset), .op_start(op_start), .op_done(op_done), .regs(regs),
      .in_addr(in_addr), .out_addr(out_addr), .dma_start(dma_start), .dma_addr(dma_addr),
      .dma_len(dma_len), .dma_idle(dma_idle), .dma_active(dma_active), .rd_valid(rd_valid),
      .rd_data(rd_data), .rd_almostfull(rd_almostfull), .bram_we(bram_we),
      .bram_waddr(bram_waddr), .bram_wdata(bram_wdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0, bad = 0;

   logic [NCH-1:0] obs_we[$];
   logic [AW-1:0]  obs_addr[$];
   logic [511:0]   obs_data[$];
   logic [511:0]   sent[$];
   int             dma_start_cnt, dma_start_cyc, op_done_cnt, op_done_cyc;
   logic [CW-1:0]  dma_addr_seen;
   logic [32:0]    dma_len_seen;
   int             t0, last_valid_cyc, af_bad;
   logic           af_after;
   bit             af_taken;

   always @(negedge clk) begin
      if (reset) begin
         if (bram_we != '0) begin
            obs_we.push_back(bram_we);
            obs_addr.push_back(bram_waddr);
            obs_data.push_back(bram_wdata);
         end
         if (dma_start) begin
            dma_start_cnt++;
            dma_start_cyc = cyc;
            dma_addr_seen = dma_addr;
            dma_len_seen  = dma_len;
         end
         if (op_done) begin
            op_done_cnt++;
            op_done_cyc = cyc;
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic rstep();
      step();
      if (!af_taken) begin
         af_after = rd_almostfull;
         af_taken = 1'b1;
      end
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Reference: k-th line lands at S + k, or S + (k mod D) when a wrap depth is set.
   function automatic logic [AW-1:0] ref_ptr(input logic [AW-1:0] s, input logic [AW-1:0] d, input int k);
      int v;
      v = (d == '0) ? (int'(s) + k) : (int'(s) + (k % int'(d)));
      return AW'(v);
   endfunction

   task automatic do_op(input bit sel, input logic [30:0] off, input logic [31:0] o0, o1, o2,
                        input logic [31:0] len, input logic [3:0] ch, input logic [AW-1:0] s, d,
                        input int idle_delay, input int n_send, input int extra, input bit wait_done);
      int n;
      regs = '0;
      regs[0] = o0; regs[1] = o1; regs[2] = o2;
      regs[3] = {sel, off};
      regs[4] = len;
      regs[5] = {28'd0, ch};
      regs[6] = 32'(s);
      regs[7] = 32'(d);
      obs_we.delete(); obs_addr.delete(); obs_data.delete(); sent.delete();
      dma_start_cnt = 0; op_done_cnt = 0; af_bad = 0; af_after = 1'bx; af_taken = 1'b0;
      last_valid_cyc = 0; op_done_cyc = 0; dma_start_cyc = 0;
      dma_idle = (idle_delay == 0);
      op_start = 1'b1;
      t0 = cyc;
      n = 0;
      while (dma_start_cnt == 0 && op_done_cnt == 0 && n < idle_delay + 30) begin
         step();
         n++;
         if (n == 1) op_start = 1'b0;
         if (n == idle_delay) dma_idle = 1'b1;
         if (dma_start_cnt == 0 && rd_almostfull !== 1'b1) af_bad++;
      end
      op_start = 1'b0;
      dma_idle = 1'b1;
      if (dma_start_cnt != 0) begin
         dma_active = 1'b1;
         for (int i = 0; i < n_send + extra; i++) begin
            int gap;
            gap = (i < n_send) ? $urandom_range(0, 2) : 0;
            repeat (gap) rstep();
            rd_valid = 1'b1;
            rd_data  = rand_line();
            if (i < n_send) begin
               sent.push_back(rd_data);
               last_valid_cyc = cyc;
            end
            rstep();
            rd_valid = 1'b0;
         end
         dma_active = 1'b0;
      end
      if (wait_done) begin
         n = 0;
         while (op_done_cnt == 0 && n < 20) begin
            step();
            n++;
         end
         repeat (3) step();
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      step();
      step();
      total++; if (op_done !== 1'b0) begin bad++; $display("FAIL reset_op_done got=%b want=0", op_done); end
      total++; if (dma_start !== 1'b0) begin bad++; $display("FAIL reset_dma_start got=%b want=0", dma_start); end
      total++; if (bram_we !== '0) begin bad++; $display("FAIL reset_bram_we got=%b want=0", bram_we); end
      total++; if (dma_addr !== '0 || dma_len !== '0) begin bad++; $display("FAIL reset_dma_fields got=%h/%h want=0/0", dma_addr, dma_len); end
      total++; if (bram_waddr !== '0 || bram_wdata !== '0) begin bad++; $display("FAIL reset_bram_fields got=%h/%h want=0/0", bram_waddr, bram_wdata[31:0]); end
      total++; if (rd_almostfull !== 1'b1) begin bad++; $display("FAIL reset_almostfull got=%b want=1", rd_almostfull); end
      reset = 1'b1;
      step();
      $display("reset checked");
   endtask

   task automatic test_basic();
      out_addr = CW'(64'h1000);
      in_addr  = CW'(64'h5555);
      do_op(1'b0, 31'h10, 32'd1, 32'd2, 32'd3, 32'd4, 4'd0, '0, '0, 0, 4, 0, 1'b1);
      total++; if (dma_start_cnt !== 1) begin bad++; $display("FAIL basic_dma_start_count got=%0d want=1", dma_start_cnt); end
      total++; if (dma_addr_seen !== CW'(64'h1016)) begin bad++; $display("FAIL basic_dma_addr got=%h want=1016", dma_addr_seen); end
      total++; if (dma_len_seen !== 33'd4) begin bad++; $display("FAIL basic_dma_len got=%0d want=4", dma_len_seen); end
      total++; if (dma_start_cyc - t0 !== 5) begin bad++; $display("FAIL basic_dma_latency got=%0d want=5", dma_start_cyc - t0); end
      total++; if (obs_we.size() !== 4) begin bad++; $display("FAIL basic_write_count got=%0d want=4", obs_we.size()); end
      for (int i = 0; i < obs_we.size() && i < 4; i++) begin
         total++;
         if (obs_we[i] !== 2'b01 || obs_addr[i] !== AW'(i) || obs_data[i] !== sent[i])
            begin bad++; $display("FAIL basic_write%0d got=we%b@%0d/%h want=we01@%0d/%h", i, obs_we[i], obs_addr[i], obs_data[i][31:0], i, sent[i][31:0]); end
      end
      total++; if (op_done_cnt !== 1 || op_done_cyc - last_valid_cyc !== 2) begin bad++; $display("FAIL basic_done got=%0d pulses lat=%0d want=1 pulse lat=2", op_done_cnt, op_done_cyc - last_valid_cyc); end
      total++; if (af_after !== 1'b0) begin bad++; $display("FAIL basic_almostfull got=%b want=0", af_after); end
      $display("op basic: addr=%h len=%0d writes=%0d", dma_addr_seen, dma_len_seen, obs_we.size());
   endtask

   task automatic test_len_zero();
      in_addr = CW'(64'h2000);
      do_op(1'b1, 31'h0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, '0, '0, 0, 0, 0, 1'b1);
      total++; if (dma_start_cnt !== 0) begin bad++; $display("FAIL len0_dma_start got=%0d want=0", dma_start_cnt); end
      total++; if (obs_we.size() !== 0) begin bad++; $display("FAIL len0_writes got=%0d want=0", obs_we.size()); end
      total++; if (op_done_cnt !== 1 || op_done_cyc - t0 !== 2) begin bad++; $display("FAIL len0_done got=%0d pulses lat=%0d want=1 pulse lat=2", op_done_cnt, op_done_cyc - t0); end
      $display("op len0: done_latency=%0d", op_done_cyc - t0);
   endtask

   task automatic test_wrap();
      logic [AW-1:0] want [6];
      want = '{10'd8, 10'd9, 10'd10, 10'd11, 10'd8, 10'd9};
      do_op(1'b0, 31'h0, 32'd0, 32'd0, 32'd0, 32'd6, 4'd1, 10'd8, 10'd4, 0, 6, 2, 1'b1);
      total++; if (obs_we.size() !== 6) begin bad++; $display("FAIL wrap_write_count got=%0d want=6", obs_we.size()); end
      for (int i = 0; i < obs_we.size() && i < 6; i++) begin
         total++;
         if (obs_we[i] !== 2'b10 || obs_addr[i] !== want[i] || obs_data[i] !== sent[i])
            begin bad++; $display("FAIL wrap_write%0d got=we%b@%0d want=we10@%0d", i, obs_we[i], obs_addr[i], want[i]); end
      end
      total++; if (op_done_cnt !== 1 || op_done_cyc - last_valid_cyc !== 2) begin bad++; $display("FAIL wrap_done got=%0d pulses lat=%0d want=1 pulse lat=2", op_done_cnt, op_done_cyc - last_valid_cyc); end
      $display("op wrap: writes=%0d", obs_we.size());
   endtask

   task automatic test_idle_wait();
      do_op(1'b0, 31'h0, 32'd0, 32'd0, 32'd0, 32'd2, 4'd0, 10'd5, '0, 14, 2, 0, 1'b1);
      total++; if (dma_start_cyc - t0 !== 15) begin bad++; $display("FAIL idle_dma_latency got=%0d want=15", dma_start_cyc - t0); end
      total++; if (af_bad !== 0) begin bad++; $display("FAIL idle_almostfull_early got=%0d cycles low want=0", af_bad); end
      total++; if (af_after !== 1'b0) begin bad++; $display("FAIL idle_almostfull_read got=%b want=0", af_after); end
      total++; if (obs_we.size() !== 2) begin bad++; $display("FAIL idle_write_count got=%0d want=2", obs_we.size()); end
      $display("op idle_wait: dma_latency=%0d", dma_start_cyc - t0);
   endtask

   task automatic test_bad_channel();
      do_op(1'b0, 31'h0, 32'd0, 32'd0, 32'd0, 32'd3, 4'd5, '0, '0, 0, 3, 0, 1'b1);
      total++; if (obs_we.size() !== 0) begin bad++; $display("FAIL badch_writes got=%0d want=0", obs_we.size()); end
      total++; if (op_done_cnt !== 1 || op_done_cyc - last_valid_cyc !== 2) begin bad++; $display("FAIL badch_done got=%0d pulses lat=%0d want=1 pulse lat=2", op_done_cnt, op_done_cyc - last_valid_cyc); end
      $display("op bad_channel: writes=%0d done=%0d", obs_we.size(), op_done_cnt);
   endtask

   task automatic test_reset_abort();
      do_op(1'b0, 31'h0, 32'd0, 32'd0, 32'd0, 32'd5, 4'd0, '0, '0, 0, 2, 0, 1'b0);
      total++; if (bram_we !== 2'b01 || obs_we.size() !== 2) begin bad++; $display("FAIL abort_pre got=we%b n%0d want=we01 n2", bram_we, obs_we.size()); end
      reset = 1'b0;
      #1;
      total++; if (bram_we !== '0) begin bad++; $display("FAIL abort_we got=%b want=0", bram_we); end
      total++; if (rd_almostfull !== 1'b1) begin bad++; $display("FAIL abort_almostfull got=%b want=1", rd_almostfull); end
      step();
      step();
      reset = 1'b1;
      step();
      do_op(1'b0, 31'h0, 32'd0, 32'd0, 32'd0, 32'd1, 4'd0, 10'd3, '0, 0, 1, 0, 1'b1);
      total++; if (dma_start_cyc - t0 !== 5) begin bad++; $display("FAIL abort_restart_latency got=%0d want=5", dma_start_cyc - t0); end
      total++; if (obs_we.size() !== 1 || obs_addr[0] !== 10'd3) begin bad++; $display("FAIL abort_restart_write got=n%0d want=n1@3", obs_we.size()); end
      total++; if (op_done_cnt !== 1) begin bad++; $display("FAIL abort_restart_done got=%0d want=1", op_done_cnt); end
      $display("op abort_restart: writes=%0d", obs_we.size());
   endtask

   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         bit            sel;
         logic [30:0]   off;
         logic [31:0]   o0, o1, o2, len;
         logic [3:0]    ch;
         logic [AW-1:0] s, d;
         logic [CW-1:0] ea;
         logic [NCH-1:0] ewe;
         int            idle, extra, nw;
         sel = 1'($urandom); off = 31'($urandom);
         o0 = $urandom; o1 = $urandom; o2 = $urandom;
         in_addr = CW'({$urandom, $urandom}); out_addr = CW'({$urandom, $urandom});
         len = 32'($urandom_range(1, 8)); ch = 4'($urandom_range(0, 3));
         s = AW'($urandom_range(0, 1023));
         d = ($urandom_range(0, 2) == 0) ? '0 : AW'($urandom_range(1, 5));
         idle = $urandom_range(0, 8); extra = $urandom_range(0, 2);
         ea = sel ? in_addr : out_addr;
         ea = ea + CW'(off) + CW'(o0) + CW'(o1) + CW'(o2);
         ewe = (int'(ch) < NCH) ? NCH'(1 << ch) : '0;
         nw = (ewe == '0) ? 0 : int'(len);
         do_op(sel, off, o0, o1, o2, len, ch, s, d, idle, int'(len), extra, 1'b1);
         total++; if (dma_start_cnt !== 1 || dma_addr_seen !== ea || dma_len_seen !== {1'b0, len})
            begin bad++; $display("FAIL rand%0d_dma got=n%0d %h/%0d want=n1 %h/%0d", it, dma_start_cnt, dma_addr_seen, dma_len_seen, ea, len); end
         total++; if (dma_start_cyc - t0 !== ((idle + 1 > 5) ? idle + 1 : 5))
            begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", it, dma_start_cyc - t0, (idle + 1 > 5) ? idle + 1 : 5); end
         total++; if (obs_we.size() !== nw) begin bad++; $display("FAIL rand%0d_write_count got=%0d want=%0d", it, obs_we.size(), nw); end
         for (int i = 0; i < obs_we.size() && i < nw; i++) begin
            total++;
            if (obs_we[i] !== ewe || obs_addr[i] !== ref_ptr(s, d, i) || obs_data[i] !== sent[i])
               begin bad++; $display("FAIL rand%0d_write%0d got=we%b@%0d/%h want=we%b@%0d/%h", it, i, obs_we[i], obs_addr[i], obs_data[i][31:0], ewe, ref_ptr(s, d, i), sent[i][31:0]); end
         end
         total++; if (op_done_cnt !== 1 || op_done_cyc - last_valid_cyc !== 2)
            begin bad++; $display("FAIL rand%0d_done got=%0d pulses lat=%0d want=1 pulse lat=2", it, op_done_cnt, op_done_cyc - last_valid_cyc); end
         $display("op rand%0d: addr=%h len=%0d ch=%0d S=%0d D=%0d writes=%0d", it, dma_addr_seen, len, ch, s, d, obs_we.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_wrap();
      test_idle_wait();
      test_bad_channel();
      test_reset_abort();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
